// File: rtl/doorlock_sup_pkg.sv
// Shared types and default tuning constants for the doorlock supervisor.
package doorlock_sup_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    OPEN,
    FAIL_WAIT,
    LOCKOUT
  } state_t;

  localparam int DEF_OPEN_CYCLES  = 100;
  localparam int DEF_LOCK_CYCLES  = 1000;
  localparam int DEF_RETRY_CYCLES = 4;
  localparam int DEF_MAX_FAIL     = 3;
  localparam int DEF_FAIL_W       = 2;
  localparam int DEF_TIMER_W      = 16;

endpackage

// File: rtl/sup_timer.sv
// Loadable down-counter; load wins over decrement, holds at zero (never underflows).
// zero is a combinational decode of the registered count.
module sup_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TIMER_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/doorlock_supervisor.sv
// Supervisor around the doorlock keypad FSM: gating, fail counting, lockout and unlock timing.
// Flag to output latency 1 clock; DOORLOCK_SUP_ALARM_EN adds a registered alarm output.
module doorlock_supervisor
  import doorlock_sup_pkg::*;
#(
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int RETRY_CYCLES = DEF_RETRY_CYCLES,
  parameter int MAX_FAIL     = DEF_MAX_FAIL,
  parameter int FAIL_W       = DEF_FAIL_W,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cover_i,
  input  logic              bt_1_i,
  input  logic              bt_2_i,
  input  logic              bt_3_i,
  input  logic              led_o,
  input  logic              led_f,
  output logic              bt_1_o,
  output logic              bt_2_o,
  output logic              bt_3_o,
  output logic              cover_o,
  output logic              unlock,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_cnt
`ifdef DOORLOCK_SUP_ALARM_EN
  ,
  output logic              alarm
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [FAIL_W-1:0]   w_fail_nxt;
  logic                w_load;
  logic [TIMER_W-1:0]  w_load_val;
  logic                w_tmr_zero;

  sup_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fail_cnt <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (cover_i) w_state_nxt = ENTRY;
      end
      ENTRY: begin
        // Success outranks failure, and either flag outranks an abandoned attempt.
        if (led_o) begin
          w_state_nxt = OPEN;
          w_fail_nxt  = '0;
          w_load      = 1'b1;
          w_load_val  = TIMER_W'(OPEN_CYCLES - 1);
        end else if (led_f) begin
          w_load = 1'b1;
          if (r_fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
            w_state_nxt = LOCKOUT;
            w_fail_nxt  = FAIL_W'(MAX_FAIL);
            w_load_val  = TIMER_W'(LOCK_CYCLES - 1);
          end else begin
            w_state_nxt = FAIL_WAIT;
            if (r_fail_cnt < FAIL_W'(MAX_FAIL)) w_fail_nxt = r_fail_cnt + FAIL_W'(1);
            w_load_val  = TIMER_W'(RETRY_CYCLES - 1);
          end
        end else if (!cover_i) begin
          w_state_nxt = IDLE;
        end
      end
      OPEN: begin
        if (w_tmr_zero) w_state_nxt = IDLE;
      end
      FAIL_WAIT: begin
        if (w_tmr_zero) w_state_nxt = cover_i ? ENTRY : IDLE;
      end
      LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = IDLE;
          w_fail_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding cover_o low outside ENTRY/OPEN drives the doorlock back to its idle state.
  assign bt_1_o   = (r_state == ENTRY) ? bt_1_i : 1'b1;
  assign bt_2_o   = (r_state == ENTRY) ? bt_2_i : 1'b1;
  assign bt_3_o   = (r_state == ENTRY) ? bt_3_i : 1'b1;
  assign cover_o  = (r_state == ENTRY || r_state == OPEN) ? cover_i : 1'b0;
  assign unlock   = (r_state == OPEN);
  assign lockout  = (r_state == LOCKOUT);
  assign fail_cnt = r_fail_cnt;

`ifdef DOORLOCK_SUP_ALARM_EN
  logic r_alarm;
  logic w_fail_accept;

  assign w_fail_accept = (r_state == ENTRY) && !led_o && led_f;

  always_ff @(posedge clk) begin
    if (rst) r_alarm <= 1'b0;
    else     r_alarm <= w_fail_accept || (w_state_nxt == LOCKOUT);
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_doorlock_supervisor.sv
// Scoreboard bench: each stimulus cycle queues the outputs expected for that cycle; a negedge monitor pops and compares.
module tb_doorlock_supervisor;

  typedef struct packed {
    logic       unlock;
    logic       lockout;
    logic       cover_o;
    logic [2:0] bt;
    logic [1:0] fail;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cover_i;
  logic       bt_1_i, bt_2_i, bt_3_i;
  logic       led_o, led_f;
  logic       bt_1_o, bt_2_o, bt_3_o;
  logic       cover_o, unlock, lockout;
  logic [1:0] fail_cnt;
`ifdef DOORLOCK_SUP_ALARM_EN
  logic       alarm;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  doorlock_supervisor #(
    .OPEN_CYCLES  (8),
    .LOCK_CYCLES  (20),
    .RETRY_CYCLES (4),
    .MAX_FAIL     (3),
    .FAIL_W       (2),
    .TIMER_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cover_i  (cover_i),
    .bt_1_i   (bt_1_i),
    .bt_2_i   (bt_2_i),
    .bt_3_i   (bt_3_i),
    .led_o    (led_o),
    .led_f    (led_f),
    .bt_1_o   (bt_1_o),
    .bt_2_o   (bt_2_o),
    .bt_3_o   (bt_3_o),
    .cover_o  (cover_o),
    .unlock   (unlock),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
`ifdef DOORLOCK_SUP_ALARM_EN
    ,
    .alarm    (alarm)
`endif
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (unlock,lockout,cover_o,bt3,fail2) at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t e_idle(input logic [1:0] f);
    return {1'b0, 1'b0, 1'b0, 3'b111, f};
  endfunction
  function automatic obs_t e_entry(input logic cov, input logic [2:0] bt, input logic [1:0] f);
    return {1'b0, 1'b0, cov, bt, f};
  endfunction
  function automatic obs_t e_open(input logic cov);
    return {1'b1, 1'b0, cov, 3'b111, 2'd0};
  endfunction
  function automatic obs_t e_fw(input logic [1:0] f);
    return {1'b0, 1'b0, 1'b0, 3'b111, f};
  endfunction
  function automatic obs_t e_lock();
    return {1'b0, 1'b1, 1'b0, 3'b111, 2'd3};
  endfunction

  // Drive one cycle of inputs just after the edge; exp describes outputs during this same cycle.
  task automatic cyc(input string tag, input logic cov, input logic [2:0] bt,
                     input logic lo, input logic lf, input logic rs, input obs_t exp);
    @(posedge clk);
    #2;
    cover_i = cov;
    {bt_1_i, bt_2_i, bt_3_i} = bt;
    led_o = lo;
    led_f = lf;
    rst   = rs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic fail_wait(input logic [1:0] f, input logic cov_last);
    for (int i = 0; i < 4; i++)
      cyc("fail_wait", (i == 3) ? cov_last : 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, e_fw(f));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {unlock, lockout, cover_o, bt_1_o, bt_2_o, bt_3_o, fail_cnt}, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cover_i = 1'b1; {bt_1_i, bt_2_i, bt_3_i} = 3'b000; led_o = 1'b0; led_f = 1'b0;

    cyc("reset",     1'b1, 3'b000, 1'b0, 1'b0, 1'b1, e_idle(2'd0));
    cyc("reset",     1'b1, 3'b000, 1'b0, 1'b0, 1'b1, e_idle(2'd0));
    cyc("reset_rel", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, e_idle(2'd0));

    cyc("entry_ok", 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, e_entry(1'b1, 3'b101, 2'd0));
    for (int i = 0; i < 8; i++) cyc("open", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, e_open(1'b1));
    cyc("post_open_idle", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd0));

    cyc("entry_f1", 1'b1, 3'b110, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b110, 2'd0));
    fail_wait(2'd1, 1'b1);
    cyc("retry_entry_f2", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd1));
    fail_wait(2'd2, 1'b0);
    cyc("expire_idle", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd2));
    cyc("entry_f3", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd2));
    for (int i = 0; i < 20; i++) cyc("lockout", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, e_lock());
    cyc("post_lock_idle", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd0));

    cyc("entry_a1", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd0));
    fail_wait(2'd1, 1'b1);
    cyc("entry_a2", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd1));
    fail_wait(2'd2, 1'b1);
    cyc("abandon", 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, e_entry(1'b0, 3'b011, 2'd2));
    cyc("abandon_idle", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd2));
    cyc("both_flags", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd2));
    for (int i = 0; i < 8; i++)
      cyc("open_clear", (i < 4), 3'b000, 1'b0, 1'b0, 1'b0, e_open(i < 4));
    cyc("idle_no_cover", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd0));
    cyc("idle_cover",    1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_idle(2'd0));

    cyc("entry_r1", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd0));
    fail_wait(2'd1, 1'b1);
    cyc("entry_r2", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd1));
    fail_wait(2'd2, 1'b1);
    cyc("entry_r3", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, e_entry(1'b1, 3'b111, 2'd2));
    for (int i = 0; i < 10; i++)
      cyc("lock_pre_rst", 1'b1, 3'b000, 1'b0, 1'b0, (i == 9), e_lock());
`ifdef DOORLOCK_SUP_ALARM_EN
    check_eq("alarm_in_lockout", {7'd0, alarm}, 8'd1);
`endif
    cyc("rst_mid_lock", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, e_idle(2'd0));
`ifdef DOORLOCK_SUP_ALARM_EN
    check_eq("alarm_after_rst", {7'd0, alarm}, 8'd0);
`endif
    cyc("entry_after_rst", 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, e_entry(1'b1, 3'b010, 2'd0));
    cyc("entry_hold",      1'b1, 3'b111, 1'b0, 1'b0, 1'b0, e_entry(1'b1, 3'b111, 2'd0));

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doorlock_supervisor.md
Name: doorlock_supervisor

Overview:
- Supervisory controller wrapped around the doorlock keypad FSM.
- Gates the doorlock's raw buttons and cover input, and watches its led_o/led_f result flags.
- Counts consecutive failed entries, enforces a timed lockout after MAX_FAIL failures, and times the unlock relay after a success.
- Forces the doorlock back to its idle state between attempts by holding its cover input low.

Parameters:
- OPEN_CYCLES, 100: cycles unlock stays asserted after a success.
- LOCK_CYCLES, 1000: lockout duration in cycles.
- RETRY_CYCLES, 4: cycles cover_o is held low after a single failure.
- MAX_FAIL, 3: consecutive failures that trigger lockout. Must be <= 2^FAIL_W-1.
- FAIL_W, 2: width of fail_cnt.
- TIMER_W, 16: down-counter width. Must hold max(OPEN, LOCK, RETRY)-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cover  in  1  user cover sensor, 1 = covered
- bt_1_i, bt_2_i, bt_3_i  in  1 each  raw buttons, active-low
- led_o  in  1  doorlock success flag
- led_f  in  1  doorlock failure flag
- bt_1_o, bt_2_o, bt_3_o  out  1 each  gated buttons to doorlock, active-low
- cover_o  out  1  gated cover to doorlock
- unlock  out  1  door relay drive
- lockout  out  1  lockout indicator
- fail_cnt  out  FAIL_W  consecutive failure count

Behaviour:
- Reset:
  - Reset is synchronous and active-high on rst, sampled on posedge clk.
  - Values: state=IDLE, timer=0, fail_cnt=0, unlock=0, lockout=0, cover_o=0, bt_*_o=1.
  - Reset overrides all events, including mid-lockout and mid-open.
- Outputs are combinational decodes of registered state:
  - bt_k_o = bt_k_i in ENTRY, else 1.
  - cover_o = cover in ENTRY and OPEN, else 0.
  - unlock = (state==OPEN).
  - lockout = (state==LOCKOUT).
- States and transitions (evaluated each posedge; results visible the next cycle):
  - IDLE:
    - cover=1 -> ENTRY.
    - IDLE lasts at least 1 cycle, so the doorlock sees cover_o=0 and returns to its idle state.
  - ENTRY:
    - led_o=1 -> OPEN; fail_cnt<=0; timer<=OPEN_CYCLES-1.
    - Else led_f=1 and fail_cnt==MAX_FAIL-1 -> LOCKOUT; fail_cnt<=MAX_FAIL; timer<=LOCK_CYCLES-1.
    - Else led_f=1 -> FAIL_WAIT; fail_cnt<=fail_cnt+1; timer<=RETRY_CYCLES-1.
    - Else cover=0 -> IDLE (abandoned attempt, fail_cnt kept).
    - led_o has priority over led_f; both flags have priority over cover=0.
  - OPEN:
    - Timer decrements each cycle; timer==0 -> IDLE.
    - cover is ignored; unlock is high exactly OPEN_CYCLES cycles.
  - FAIL_WAIT:
    - Timer decrements; at timer==0 -> ENTRY if cover=1, else IDLE.
  - LOCKOUT:
    - Timer decrements; at timer==0 -> IDLE and fail_cnt<=0.
    - All buttons and cover are masked for exactly LOCK_CYCLES cycles.
- Width rules:
  - fail_cnt saturates at MAX_FAIL and never wraps.
  - Timer never underflows: it is only decremented when nonzero.
- Latency:
  - Flag to state change: 1 clock.
  - Flag to output change: 1 clock, since outputs decode state.

Optional Feature:
- Macro: DOORLOCK_SUP_ALARM_EN.
- Defined:
  - Adds output port alarm (1 bit, reset 0).
  - alarm is registered: high for the 1 cycle following each led_f acceptance in ENTRY, and continuously high during LOCKOUT.
- Undefined:
  - No alarm port and no alarm logic; all other behaviour is identical.

Decomposition:
- Package doorlock_sup_pkg:
  - State enum {IDLE, ENTRY, OPEN, FAIL_WAIT, LOCKOUT}.
  - Default parameter constants.
- Sub-module sup_timer:
  - Loadable TIMER_W down-counter with ports load, load_val, zero flag.
  - Synchronous active-high reset.
  - One instance, shared across OPEN, FAIL_WAIT and LOCKOUT.

Test Plan (OPEN_CYCLES=8, LOCK_CYCLES=20, RETRY_CYCLES=4, MAX_FAIL=3):
1. Reset: rst=1 for 2 cycles with cover=1 and bt_*_i=0 -> unlock=0, lockout=0, cover_o=0, bt_*_o=1, fail_cnt=0. ENTRY is reached 1 cycle after rst drops.
2. Success: cover=1, led_o pulse in ENTRY -> next cycle unlock=1 for exactly 8 cycles with bt_*_o=1 and fail_cnt=0. Then 1 IDLE cycle with cover_o=0, then ENTRY.
3. Single fail: led_f pulse in ENTRY -> fail_cnt=1 and cover_o=0 for 4 cycles, then ENTRY with cover held 1. If cover=0 at expiry -> IDLE.
4. Lockout: three led_f pulses across three ENTRY periods -> fail_cnt=3 and lockout=1 for 20 cycles. During lockout, bt_1_i=0 still gives bt_1_o=1 and cover_o=0. After lockout: fail_cnt=0, state IDLE.
5. Abandon and clear: two fails then cover=0 in ENTRY -> IDLE with fail_cnt=2 retained. Subsequent led_o -> fail_cnt=0. Simultaneous led_o=1 and led_f=1 -> OPEN taken.
6. Reset mid-lockout: rst=1 at lockout cycle 10 -> next cycle lockout=0, fail_cnt=0, state IDLE. With DOORLOCK_SUP_ALARM_EN, alarm=0 on that cycle.
